grid_readout: RTL and testbench
===============================

// Module: grid_readout
// PURPOSE
//  Read-side engine for the accumulating grid memory: streams a contiguous run of BRAM words
//  (BRAM_PARALLELISM complex samples each) out of the grid's read port onto a valid/ready bus.
//  Sits between the grid BRAM and the downstream FFT/host DMA; holds no grid state itself.
// PARAMETERS
//  COMPLEX                2   words per sample (re, im)
//  PRECISION              32  bits per float32 component
//  BRAM_PARALLELISM_BITS  4   log2 samples per BRAM word (16)
//  BRAM_DEPTH_BITS        10  log2 BRAM words in grid (1024)
//  RD_LATENCY             2   grid read latency, cycles from mem_re to mem_rdata valid (>=1)
//  derived: BRAM_WIDTH = 2**BRAM_PARALLELISM_BITS*PRECISION*COMPLEX (1024); FIFO_DEPTH = RD_LATENCY+2
// PORTS
//  clk        in   1                   clock, all logic on posedge
//  rst        in   1                   reset, synchronous, active-high
//  start      in   1                   one-cycle pulse: latch base/count, begin run (ignored when busy)
//  base       in   BRAM_DEPTH_BITS     first BRAM word address
//  count      in   BRAM_DEPTH_BITS+1   number of words to read, 0..2**BRAM_DEPTH_BITS
//  busy       out  1                   high from accepted start until done
//  done       out  1                   one-cycle pulse when run complete
//  mem_re     out  1                   grid read enable
//  mem_raddr  out  BRAM_DEPTH_BITS     grid read word address
//  mem_rdata  in   BRAM_WIDTH          grid read data, valid RD_LATENCY cycles after mem_re
//  mem_we     out  1                   grid clear-write enable (GRID_CLEAR_ON_READ_EN only, else 0)
//  mem_waddr  out  BRAM_DEPTH_BITS     grid clear-write address
//  mem_wdata  out  BRAM_WIDTH          clear-write data, constant 0
//  out_data   out  BRAM_WIDTH          streamed word, sample 0 in LSBs
//  out_valid  out  1                   out_data valid
//  out_ready  in   1                   downstream accept; transfer = out_valid & out_ready
//  out_last   out  1                   marks final word of run (qualified by out_valid)
// BEHAVIOUR
//  - Reset: busy=done=mem_re=mem_we=out_valid=out_last=0, addresses 0, FIFO empty, state IDLE.
//  - FSM IDLE -> ISSUE on start; ISSUE -> DRAIN when count reads issued; DRAIN -> IDLE when last
//    word transferred (done=1 that cycle+1, i.e. registered pulse). start with count=0: done pulse
//    next cycle, no reads, no output, busy high exactly one cycle.
//  - Reads issued in order base, base+1, ...; address wraps modulo 2**BRAM_DEPTH_BITS.
//  - Credit rule: mem_re=1 only if in_flight + fifo_count < FIFO_DEPTH; a shift register of
//    RD_LATENCY tracks in-flight reads and writes returning data into FIFO. No word ever dropped.
//  - With out_ready held 1: one word/cycle; first out_valid RD_LATENCY+1 cycles after start.
//  - out_data/out_valid held stable while out_valid & ~out_ready.
//  - out_last=1 only on the count-th word. start while busy: ignored, no effect on run.
//  - rst mid-run: aborts immediately, FIFO flushed, in-flight returns discarded, no done pulse.
// CONFIGURATION
//  GRID_CLEAR_ON_READ_EN defined: when word at address A returns from the grid, mem_we=1,
//  mem_waddr=A, mem_wdata=0 that cycle, leaving the grid zeroed for next accumulation pass.
//  Undefined: mem_we tied 0, mem_waddr/mem_wdata tied 0, grid unchanged by readout.
// STRUCTURE
//  - grid_pkg: COMPLEX, PRECISION, BRAM_PARALLELISM_BITS, BRAM_DEPTH_BITS constants, BRAM_WIDTH,
//    state enum {IDLE, ISSUE, DRAIN}.
//  - Sub-module grid_readout_fifo: synchronous FIFO, width BRAM_WIDTH, depth FIFO_DEPTH, with count.
// TESTING
//  1. Preload word k = {16{k,k}}; start base=0 count=8, out_ready=1 -> words 0..7 back-to-back,
//     first valid at cycle 3 after start, out_last on word 7, done one cycle later.
//  2. base=0x3FE count=4 -> addresses 0x3FE,0x3FF,0x000,0x001 read, data in that order.
//  3. count=16, out_ready toggled 1/0 every cycle and random stalls of 5 -> all 16 words, in order,
//     no duplication; in_flight+fifo_count never exceeds 4.
//  4. count=0 -> done pulse next cycle, mem_re never asserted, out_valid stays 0.
//  5. rst asserted mid-run after 3 words -> all outputs 0 next cycle; new start base=0x10 count=2
//     returns exactly words 0x10,0x11.
//  6. GRID_CLEAR_ON_READ_EN: read 8 words, then re-read -> second pass all zeros; without macro
//     second pass equals first.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared constants and types for the grid readout engine.
package grid_pkg;

  localparam int COMPLEX               = 2;
  localparam int PRECISION             = 32;
  localparam int BRAM_PARALLELISM_BITS = 4;
  localparam int BRAM_DEPTH_BITS       = 10;
  localparam int BRAM_WIDTH            = (2 ** BRAM_PARALLELISM_BITS) * PRECISION * COMPLEX;
  localparam int RD_LATENCY_DEFAULT    = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  function automatic int fifo_depth(input int rd_latency);
    return rd_latency + 2;
  endfunction

endpackage

// File: rtl/grid_readout_fifo.sv
// Small synchronous FIFO holding returned grid words until the downstream accepts them.
module grid_readout_fifo
  import grid_pkg::*;
#(
  parameter int WIDTH = BRAM_WIDTH,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/grid_readout.sv
// Streams a contiguous run of grid BRAM words onto a valid/ready bus.
// Optional GRID_CLEAR_ON_READ_EN zeroes each word as it returns from the grid.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | issuing reads, limited by FIFO credit
// DRAIN | all reads issued, emptying FIFO
module grid_readout
  import grid_pkg::*;
#(
  parameter int RD_LATENCY = RD_LATENCY_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [BRAM_DEPTH_BITS-1:0] base,
  input  logic [BRAM_DEPTH_BITS:0]   count,
  output logic                       busy,
  output logic                       done,
  output logic                       mem_re,
  output logic [BRAM_DEPTH_BITS-1:0] mem_raddr,
  input  logic [BRAM_WIDTH-1:0]      mem_rdata,
  output logic                       mem_we,
  output logic [BRAM_DEPTH_BITS-1:0] mem_waddr,
  output logic [BRAM_WIDTH-1:0]      mem_wdata,
  output logic [BRAM_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last
);

  localparam int FIFO_DEPTH = fifo_depth(RD_LATENCY);
  localparam int OW         = $clog2(FIFO_DEPTH + 1);
  localparam int CW         = BRAM_DEPTH_BITS + 1;
  localparam logic [OW-1:0] FIFO_DEPTH_W = OW'(FIFO_DEPTH);

  state_t                state;
  logic [CW-1:0]         issue_left;
  logic [CW-1:0]         out_left;
  logic [OW-1:0]         occ;
  logic [OW-1:0]         occ_after_pop;
  logic [OW-1:0]         fifo_count;
  logic [RD_LATENCY-1:0] pipe_v;
  logic                  pop;
  logic                  issue_nxt;

  assign pop           = out_valid & out_ready;
  assign out_valid     = (fifo_count != '0);
  assign out_last      = out_valid && (out_left == CW'(1));
  assign occ_after_pop = occ - OW'(pop);

  // occ counts every read from issue until its word leaves the FIFO, so
  // granting only while it stays within FIFO_DEPTH means returns never overflow.
  always_comb begin
    issue_nxt = 1'b0;
    case (state)
      IDLE:    issue_nxt = start && (count != '0);
      ISSUE:   issue_nxt = (issue_left != '0) && (occ_after_pop < FIFO_DEPTH_W);
      default: issue_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_re     <= 1'b0;
      mem_raddr  <= '0;
      issue_left <= '0;
      out_left   <= '0;
      occ        <= '0;
      pipe_v     <= '0;
    end else begin
      done      <= 1'b0;
      mem_re    <= issue_nxt;
      occ       <= occ_after_pop + OW'(issue_nxt);
      pipe_v[0] <= mem_re;
      for (int i = 1; i < RD_LATENCY; i++) pipe_v[i] <= pipe_v[i-1];
      if (pop) out_left <= out_left - CW'(1);

      case (state)
        IDLE: begin
          if (start) begin
            state      <= ISSUE;
            busy       <= 1'b1;
            mem_raddr  <= base;
            issue_left <= issue_nxt ? count - CW'(1) : '0;
            out_left   <= count;
          end
        end
        ISSUE: begin
          if (issue_nxt) begin
            mem_raddr  <= mem_raddr + BRAM_DEPTH_BITS'(1);
            issue_left <= issue_left - CW'(1);
          end
          if (issue_left == '0) state <= DRAIN;
        end
        DRAIN: ;
        default: state <= IDLE;
      endcase

      // Zero-length runs finish here too, one cycle after start.
      if (state != IDLE && (out_left == '0 || (pop && out_left == CW'(1)))) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end
  end

  grid_readout_fifo #(
    .WIDTH (BRAM_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .CW    (OW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pipe_v[RD_LATENCY-1]),
    .wdata (mem_rdata),
    .pop   (pop),
    .rdata (out_data),
    .count (fifo_count)
  );

`ifdef GRID_CLEAR_ON_READ_EN
  logic [BRAM_DEPTH_BITS-1:0] pipe_a [RD_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) pipe_a[i] <= '0;
    end else begin
      pipe_a[0] <= mem_raddr;
      for (int i = 1; i < RD_LATENCY; i++) pipe_a[i] <= pipe_a[i-1];
    end
  end

  assign mem_we    = pipe_v[RD_LATENCY-1];
  assign mem_waddr = pipe_a[RD_LATENCY-1];
`else
  assign mem_we    = 1'b0;
  assign mem_waddr = '0;
`endif
  assign mem_wdata = '0;

endmodule

// File: tb/tb_grid_readout.sv
// Directed bench for grid_readout with a 2-cycle-latency grid memory model.
module tb_grid_readout;
  import grid_pkg::*;

  localparam int W  = BRAM_WIDTH;
  localparam int AD = BRAM_DEPTH_BITS;
  localparam int NW = 1 << AD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AD-1:0] base = '0;
  logic [AD:0]   count = '0;
  logic          out_ready = 1'b0;
  logic          busy, done, mem_re, mem_we, out_valid, out_last;
  logic [AD-1:0] mem_raddr, mem_waddr;
  logic [W-1:0]  mem_rdata, mem_wdata, out_data;

  int nvec = 0;
  int nerr = 0;

  logic [W-1:0] gmem [NW];
  logic [W-1:0] stage1;
  logic         loaded = 1'b0;
  bit           cleared [NW];

  always #5 clk = ~clk;

  grid_readout dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .count(count),
    .busy(busy), .done(done), .mem_re(mem_re), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  function automatic logic [W-1:0] pat(input int a);
    logic [31:0] k;
    k = 32'(a);
    return {16{k, k}};
  endfunction

  function automatic logic [W-1:0] exp_word(input int a);
    return cleared[a] ? '0 : pat(a);
  endfunction

  function automatic logic rdy(input int mode, input int n);
    if (mode == 0) return 1'b1;
    if ((n >= 20 && n < 25) || (n >= 40 && n < 45)) return 1'b0;
    return (n % 2) == 0;
  endfunction

  // grid model: read data appears two cycles after mem_re
  always @(posedge clk) begin
    if (!loaded) begin
      for (int k = 0; k < NW; k++) gmem[k] <= pat(k);
      loaded <= 1'b1;
    end else if (mem_we) begin
      gmem[mem_waddr] <= '0;
    end
    if (mem_re) stage1 <= gmem[mem_raddr];
    mem_rdata <= stage1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed[63:0]=%h expected[63:0]=%h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  task automatic run(input logic [AD-1:0] b, input logic [AD:0] c, input int mode,
                     input bit restart, input int exp_first, input int exp_done);
    int got, issued, first_v, done_n, last_n, busy_cyc, max_occ, a;
    logic stall_prev;
    logic [AD-1:0] ea;
    got = 0; issued = 0; first_v = -1; done_n = -1; last_n = -1;
    busy_cyc = 0; max_occ = 0; stall_prev = 1'b0;
    @(negedge clk);
    start = 1'b1; base = b; count = c; out_ready = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (restart && n == 5) begin
        start = 1'b1; base = '0; count = 1;
      end
      out_ready = rdy(mode, n);
      if (mem_re) begin
        ea = b + AD'(issued);
        check("raddr", 64'(mem_raddr), 64'(ea));
        issued++;
      end
      if (issued - got > max_occ) max_occ = issued - got;
      if (stall_prev) check("hold_valid", 64'(out_valid), 64'd1);
      if (out_valid) begin
        if (first_v < 0) first_v = n;
        a = (int'(b) + got) % NW;
        check_word("data", out_data, exp_word(a));
        check("last", 64'(out_last), 64'(got == int'(c) - 1));
      end
      if (busy) busy_cyc++;
      if (out_valid && out_ready) begin
`ifdef GRID_CLEAR_ON_READ_EN
        cleared[a] = 1'b1;
`endif
        last_n = n;
        got++;
      end
      stall_prev = out_valid && !out_ready;
      if (done) begin
        done_n = n;
        break;
      end
    end
    check("words", 64'(got), 64'(c));
    check("issued", 64'(issued), 64'(c));
    check("occ_le_depth", 64'(max_occ <= 4), 64'd1);
    check("busy_cycles", 64'(busy_cyc), 64'(done_n));
    if (c != 0) check("done_after_last", 64'(done_n), 64'(last_n + 1));
    if (exp_first != -2) check("first_valid", 64'(first_v), 64'(exp_first));
    if (exp_done != -2) check("done_cycle", 64'(done_n), 64'(exp_done));
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    int got;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mem_re", 64'(mem_re), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_raddr", 64'(mem_raddr), 64'd0);
    check("rst_waddr", 64'(mem_waddr), 64'd0);
    check("wdata_zero", 64'(mem_wdata == '0), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // back-to-back run, then re-read of the same words
    run(10'h000, 11'd8, 0, 1'b0, 3, 11);
    run(10'h000, 11'd8, 0, 1'b0, 3, 11);
    // address wrap
    run(10'h3FE, 11'd4, 0, 1'b0, 3, 7);
    // stalls, plus a start while busy
    run(10'h100, 11'd16, 1, 1'b1, -2, -2);
    // zero-length run
    run(10'h050, 11'd0, 0, 1'b0, -1, 1);

    // abort mid-run with reset
    @(negedge clk);
    start = 1'b1; base = 10'h200; count = 11'd16; out_ready = 1'b1;
    @(posedge clk);
    got = 0;
    for (int n = 0; n < 60 && got < 3; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && out_ready) got++;
    end
    check("pre_abort_words", 64'(got), 64'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_mem_re", 64'(mem_re), 64'd0);
    check("abort_mem_we", 64'(mem_we), 64'd0);
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_last", 64'(out_last), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_abort_valid", 64'(out_valid), 64'd0);
    check("post_abort_done", 64'(done), 64'd0);
    run(10'h010, 11'd2, 0, 1'b0, 3, 5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
